// File: rtl/pipeline_merge_rr_pkg.sv
// Shared helpers for the valid/bp pipeline blocks: index-width function and a
// simulation-only assertion macro.
`ifndef PIPELINE_ASSERT
`ifdef SYNTHESIS
`define PIPELINE_ASSERT(label, clk, rst, cond, msg)
`else
`define PIPELINE_ASSERT(label, clk, rst, cond, msg) \
  label: assert property (@(posedge clk) disable iff (rst) (cond)) else $error("%s", msg);
`endif
`endif

package pipeline_merge_rr_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_merge_rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping to 0.
module pipeline_rr_pick #(
  parameter int NumInputs = 4,
  parameter int IdxWidth  = 2
) (
  input  logic [NumInputs-1:0] req_i,
  input  logic [IdxWidth-1:0]  ptr_i,
  output logic [IdxWidth-1:0]  grant_o,
  output logic                 any_valid_o
);

  logic found;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NumInputs; i++) begin
      if (!found && req_i[i] && (IdxWidth'(i) >= ptr_i)) begin
        grant_o = IdxWidth'(i);
        found   = 1'b1;
      end
    end
    // Wrapped half of the search: indices below ptr.
    for (int i = 0; i < NumInputs; i++) begin
      if (!found && req_i[i]) begin
        grant_o = IdxWidth'(i);
        found   = 1'b1;
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/pipeline_merge_rr.sv
// N-input round-robin merge into a two-slot output buffer; each token keeps
// the index of the input it came from.
module pipeline_merge_rr
  import pipeline_merge_rr_pkg::*;
#(
  parameter string Name      = "",
  parameter int    Width     = 8,
  parameter int    NumInputs = 4,
  parameter int    IdxWidth  = clog2(NumInputs)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NumInputs*Width-1:0] d,
  input  logic [NumInputs-1:0]       d_valid,
  output logic [NumInputs-1:0]       d_bp,
  output logic [Width-1:0]           q,
  output logic [IdxWidth-1:0]        q_idx,
  output logic                       q_valid,
  input  logic                       q_bp
);

  logic                valid1_q, valid1_d, valid2_q, valid2_d;
  logic [Width-1:0]    data1_q, data1_d, data2_q, data2_d;
  logic [IdxWidth-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] grant;
  logic [Width-1:0]    in_data;
  logic                any_valid, can_accept, incoming, outgoing;

  pipeline_rr_pick #(
    .NumInputs (NumInputs),
    .IdxWidth  (IdxWidth)
  ) u_pick (
    .req_i       (d_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  // Space is judged on registered state only; a drain this cycle does not free a slot.
  assign can_accept = ~(valid1_q & valid2_q);
  assign incoming   = can_accept & any_valid & ~resetn;
  assign outgoing   = valid1_q & ~q_bp;

  always_comb begin
    in_data = '0;
    d_bp    = '1;
    for (int i = 0; i < NumInputs; i++) begin
      if (grant == IdxWidth'(i)) in_data = d[i*Width +: Width];
      d_bp[i] = ~(incoming & (grant == IdxWidth'(i)));
    end
  end

  assign ptr_d = !incoming ? ptr_q :
                 (grant == IdxWidth'(NumInputs - 1)) ? '0 : grant + IdxWidth'(1);

  always_comb begin
    valid1_d = valid1_q;
    data1_d  = data1_q;
    idx1_d   = idx1_q;
    valid2_d = valid2_q;
    data2_d  = data2_q;
    idx2_d   = idx2_q;
    if (outgoing) begin
      valid1_d = valid2_q;
      data1_d  = data2_q;
      idx1_d   = idx2_q;
      valid2_d = 1'b0;
    end
    if (incoming) begin
      if (!valid1_d) begin
        valid1_d = 1'b1;
        data1_d  = in_data;
        idx1_d   = grant;
      end else begin
        valid2_d = 1'b1;
        data2_d  = in_data;
        idx2_d   = grant;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      valid1_q <= 1'b0;
      data1_q  <= '0;
      idx1_q   <= '0;
      valid2_q <= 1'b0;
      data2_q  <= '0;
      idx2_q   <= '0;
      ptr_q    <= '0;
    end else begin
      valid1_q <= valid1_d;
      data1_q  <= data1_d;
      idx1_q   <= idx1_d;
      valid2_q <= valid2_d;
      data2_q  <= data2_d;
      idx2_q   <= idx2_d;
      ptr_q    <= ptr_d;
    end
  end

  assign q       = data1_q;
  assign q_idx   = idx1_q;
  assign q_valid = valid1_q;

  `PIPELINE_ASSERT(no_overflow_a, clk, resetn, !(incoming && outgoing && valid2_q), {Name, ": token arrived with both slots full"})

endmodule

// File: tb/tb_pipeline_merge_rr.sv
// Randomized bench for pipeline_merge_rr with a queue-based reference model
// plus directed scenarios pinned by literal expectations.
module tb_pipeline_merge_rr;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
  } tok_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N*W-1:0]  d;
  logic [N-1:0]    d_valid, d_bp;
  logic [W-1:0]    q;
  logic [IW-1:0]   q_idx;
  logic            q_valid, q_bp;

  logic [3*W-1:0]  d3;
  logic [2:0]      d3_valid, d3_bp;
  logic [W-1:0]    q3;
  logic [1:0]      q3_idx;
  logic            q3_valid;
  logic            q3_bp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tok_t mq[$];
  int   mptr;
  tok_t outs[$];
  int   grants[$];
  int   g_cyc[$];
  int   o_cyc[$];

  logic [W-1:0] nxt[N];
  int           budget[N];
  bit           rand_data;

  logic [2:0]   e_bp3[5]  = '{3'b110, 3'b011, 3'b110, 3'b011, 3'b110};
  int           e_idx3[5] = '{0, 0, 2, 0, 2};
  logic [W-1:0] e_dat3[5] = '{8'h00, 8'hA0, 8'hC2, 8'hA0, 8'hC2};

  pipeline_merge_rr #(.Name("m4"), .Width(W), .NumInputs(N)) dut (
    .clk(clk), .resetn(resetn), .d(d), .d_valid(d_valid), .d_bp(d_bp),
    .q(q), .q_idx(q_idx), .q_valid(q_valid), .q_bp(q_bp)
  );

  pipeline_merge_rr #(.Name("m3"), .Width(W), .NumInputs(3)) dut3 (
    .clk(clk), .resetn(resetn), .d(d3), .d_valid(d3_valid), .d_bp(d3_bp),
    .q(q3), .q_idx(q3_idx), .q_valid(q3_valid), .q_bp(q3_bp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two tokens plus a rotating start index.
  always @(negedge clk) begin
    logic [N-1:0] exp_bp;
    bit           can, exp_valid;
    int           g;
    cyc++;
    if (resetn) begin
      check($sformatf("rst q_valid c%0d", cyc), q_valid, 0);
      check($sformatf("rst q c%0d", cyc), q, 0);
      check($sformatf("rst q_idx c%0d", cyc), q_idx, 0);
      check($sformatf("rst d_bp c%0d", cyc), d_bp, 4'b1111);
      mq.delete();
      mptr = 0;
    end else begin
      exp_valid = (mq.size() > 0);
      check($sformatf("q_valid c%0d", cyc), q_valid, exp_valid);
      if (exp_valid) begin
        check($sformatf("q c%0d", cyc), q, mq[0].data);
        check($sformatf("q_idx c%0d", cyc), q_idx, mq[0].idx);
      end
      can = (mq.size() < 2);
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && d_valid[(mptr + k) % N]) g = (mptr + k) % N;
      for (int i = 0; i < N; i++) exp_bp[i] = !(can && g == i);
      check($sformatf("d_bp c%0d", cyc), d_bp, exp_bp);
      if (exp_valid && !q_bp) begin
        outs.push_back(mq[0]);
        o_cyc.push_back(cyc);
        void'(mq.pop_front());
      end
      if (can && g >= 0) begin
        mq.push_back('{data: d[g*W +: W], idx: g});
        grants.push_back(g);
        g_cyc.push_back(cyc);
        mptr = (g + 1) % N;
      end
    end
  end

  task automatic clear_logs();
    outs.delete();
    grants.delete();
    g_cyc.delete();
    o_cyc.delete();
  endtask

  task automatic do_reset();
    resetn   = 1'b1;
    d_valid  = '0;
    d3_valid = '0;
    q_bp     = 1'b0;
    for (int i = 0; i < N; i++) budget[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    clear_logs();
  endtask

  // Producers hold a token until it is taken, then offer the next one.
  task automatic run_cycles(input int ncyc, input int p_new, input int p_bp);
    logic [N-1:0] taken;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!d_valid[i] && budget[i] > 0 && $urandom_range(99) < p_new) begin
          budget[i]--;
          d_valid[i] = 1'b1;
          d[i*W +: W] = rand_data ? W'($urandom) : nxt[i];
          nxt[i]++;
        end
      end
      q_bp = ($urandom_range(99) < p_bp);
      @(negedge clk);
      taken = d_valid & ~d_bp;
      @(posedge clk);
      #1;
      d_valid = d_valid & ~taken;
    end
  endtask

  initial begin
    resetn    = 1'b1;
    d         = '0;
    d_valid   = '0;
    q_bp      = 1'b0;
    d3        = {8'hC2, 8'h00, 8'hA0};
    d3_valid  = '0;
    q3_bp     = 1'b0;
    rand_data = 1'b0;
    for (int i = 0; i < N; i++) begin
      nxt[i]    = '0;
      budget[i] = 0;
    end
    @(posedge clk);
    #1;
    check("init q_valid", q_valid, 0);
    check("init q", q, 0);
    check("init q_idx", q_idx, 0);

    // Single source: five counting tokens, one per cycle, one cycle latency.
    do_reset();
    nxt[2] = 8'h10;
    budget[2] = 5;
    run_cycles(8, 100, 0);
    check("t1 count", outs.size(), 5);
    for (int k = 0; k < 5 && k < outs.size(); k++) begin
      check($sformatf("t1 data%0d", k), outs[k].data, 8'h10 + k);
      check($sformatf("t1 idx%0d", k), outs[k].idx, 2);
    end
    if (outs.size() == 5) begin
      check("t1 latency", o_cyc[0] - g_cyc[0], 1);
      check("t1 rate", o_cyc[4] - o_cyc[0], 4);
    end

    // All inputs busy: strict rotation, one token per cycle.
    do_reset();
    for (int i = 0; i < N; i++) budget[i] = 8;
    run_cycles(10, 100, 0);
    check("t2 grants", grants.size() >= 8, 1);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      check($sformatf("t2 grant%0d", k), grants[k], k % 4);
    if (o_cyc.size() >= 8) check("t2 rate", o_cyc[7] - o_cyc[0], 7);

    // Downstream stall absorbs two tokens, then blocks all inputs.
    do_reset();
    budget[0] = 2;
    budget[1] = 2;
    run_cycles(4, 100, 100);
    check("t3 d_bp full", d_bp, 4'b1111);
    check("t3 q_idx hold", q_idx, 0);
    check("t3 q_valid hold", q_valid, 1);
    run_cycles(8, 100, 0);
    check("t3 grants", grants.size(), 4);
    check("t3 outs", outs.size(), 4);
    for (int k = 0; k < 4 && k < outs.size(); k++)
      check($sformatf("t3 out idx%0d", k), outs[k].idx, k % 2);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check($sformatf("t3 grant%0d", k), grants[k], k % 2);

    // Three-input instance: inputs 0 and 2 alternate, pointer wraps 2 -> 0.
    do_reset();
    d3_valid = 3'b101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t4 d_bp%0d", k), d3_bp, e_bp3[k]);
      check($sformatf("t4 q_valid%0d", k), q3_valid, k > 0);
      if (k > 0) begin
        check($sformatf("t4 q_idx%0d", k), q3_idx, e_idx3[k]);
        check($sformatf("t4 q%0d", k), q3, e_dat3[k]);
      end
    end
    @(posedge clk);
    #1;
    d3_valid = '0;

    // Asynchronous reset with both slots occupied.
    do_reset();
    for (int i = 0; i < N; i++) budget[i] = 10;
    run_cycles(4, 100, 100);
    check("t5 full before", q_valid, 1);
    #2;
    resetn = 1'b1;
    #1;
    check("t5 async q_valid", q_valid, 0);
    check("t5 async d_bp", d_bp, 4'b1111);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    clear_logs();
    run_cycles(6, 100, 0);
    check("t5 grant0 after reset", grants.size() > 0 ? grants[0] : -1, 0);
    check("t5 out0 idx", outs.size() > 0 ? outs[0].idx : -1, 0);

    // Pointer at 2: late arrival on 3 beats waiting input 1.
    do_reset();
    d[15:8]  = 8'h31;
    d_valid  = 4'b0010;
    run_cycles(2, 100, 0);
    d[15:8]  = 8'h32;
    d[31:24] = 8'h33;
    d_valid  = 4'b1010;
    run_cycles(5, 100, 0);
    check("t6 grants", grants.size(), 3);
    if (grants.size() == 3) begin
      check("t6 grant0", grants[0], 1);
      check("t6 grant1", grants[1], 3);
      check("t6 grant2", grants[2], 1);
    end
    if (outs.size() == 3) begin
      check("t6 out0", outs[0].data, 8'h31);
      check("t6 out1", outs[1].data, 8'h33);
      check("t6 out2", outs[2].data, 8'h32);
    end

    // Random traffic against the model.
    do_reset();
    rand_data = 1'b1;
    for (int i = 0; i < N; i++) budget[i] = 5000;
    run_cycles(1500, 60, 30);
    run_cycles(1000, 40, 70);
    run_cycles(500, 90, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
